// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : AMDS serial-link transmitter. Sends one byte per start strobe as
//            start bit, 8 data bits LSB first, odd parity and STOP_BITS stop
//            bits, each held for CLKS_PER_BIT clocks. dout, busy and
//            is_tx_done all come straight from flops.
// Options  : UART_TX_GUARD_EN -- when defined, GUARD_BITS idle-high bit
//            periods follow the stop bits before busy falls and done pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 2
`ifdef UART_TX_GUARD_EN
  ,
  parameter int GUARD_BITS   = 1
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       start_tx,
  output logic       dout,
  output logic       busy,
  output logic       is_tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_GUARD_EN
    ,
    GUARD  = 3'd5
`endif
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST  = 4'd7;
  localparam logic [3:0] STOP_LAST  = 4'(STOP_BITS - 1);
`ifdef UART_TX_GUARD_EN
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_BITS - 1);
`endif

  state_t     state;
  state_t     state_next;
  logic [7:0] shift_reg;
  logic       parity_bit;
  logic [7:0] bit_timer;
  logic [3:0] bit_cnt;
  logic       tick;
  logic       load;
  logic       finish;

  // A bit period ends on the last timer count.
  assign tick = (bit_timer == TIMER_LAST);

  // Next-state decode; load marks an accepted request, finish marks frame end.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_tx) begin
          state_next = START;
          load       = 1'b1;
        end
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick && (bit_cnt == DATA_LAST)) state_next = PARITY;
      end
      PARITY: begin
        if (tick) state_next = STOP;
      end
      STOP: begin
        if (tick && (bit_cnt == STOP_LAST)) begin
`ifdef UART_TX_GUARD_EN
          state_next = GUARD;
`else
          state_next = IDLE;
          finish     = 1'b1;
`endif
        end
      end
`ifdef UART_TX_GUARD_EN
      GUARD: begin
        if (tick && (bit_cnt == GUARD_LAST)) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: byte capture, parity, bit timer and per-state bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
      bit_timer  <= 8'd0;
      bit_cnt    <= 4'd0;
    end else if (load) begin
      shift_reg  <= tx_data;
      parity_bit <= ~^tx_data;
      bit_timer  <= 8'd0;
      bit_cnt    <= 4'd0;
    end else if (state == IDLE) begin
      bit_timer  <= 8'd0;
      bit_cnt    <= 4'd0;
    end else begin
      bit_timer <= tick ? 8'd0 : bit_timer + 8'd1;
      // The counter restarts on every state change so STOP/GUARD count from 0.
      if (state_next != state) bit_cnt <= 4'd0;
      else if (tick)           bit_cnt <= bit_cnt + 4'd1;
      if ((state == DATA) && tick) shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // Output flops: the line level trails the state by one clock, so the start
  // bit appears the edge after acceptance and the last stop cycle coincides
  // with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= 1'b1;
      busy       <= 1'b0;
      is_tx_done <= 1'b0;
    end else begin
      is_tx_done <= finish;
      busy       <= (state != IDLE) && !finish;
      case (state)
        START:   dout <= 1'b0;
        DATA:    dout <= shift_reg[0];
        PARITY:  dout <= parity_bit;
        default: dout <= 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire
